// File: rtl/matmul_job_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : matmul_job_arbiter
// Purpose  : Round-robin sharing of one matmul_array engine among NUM_REQ
//            requesters; sequences the engine start/done level handshake.
// Options  : MATMUL_ARB_PERF_EN compiles the saturating perf counters.
// Revision : 1.0 - initial release
// ============================================================================
module matmul_job_arbiter #(
    parameter  int NUM_REQ = 4,
    parameter  int CNT_W   = 32,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [NUM_REQ-1:0] job_done,
    output logic               eng_start,
    input  logic               eng_done,
    output logic [ID_W-1:0]    eng_sel,
    output logic               busy,
    output logic               proto_err,
    output logic [CNT_W-1:0]   perf_busy_cycles,
    output logic [CNT_W-1:0]   perf_jobs
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_DRAIN   = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    localparam logic [ID_W:0] C_NUM_REQ = (ID_W+1)'(NUM_REQ);

    state_t             state_q, state_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] job_done_q, job_done_d;
    logic               eng_start_q, eng_start_d;
    logic [ID_W-1:0]    eng_sel_q, eng_sel_d;
    logic               busy_q, busy_d;
    logic               proto_err_q, proto_err_d;

    logic               win_found;
    logic [ID_W-1:0]    win_idx;
    logic [ID_W:0]      scan;
    logic [ID_W:0]      ptr_next;

    // First set request at or above rr_ptr, wrapping past NUM_REQ-1 to 0.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan = {1'b0, rr_ptr_q} + (ID_W+1)'(i);
            if (scan >= C_NUM_REQ) begin
                scan = scan - C_NUM_REQ;
            end
            if (!win_found && req[scan[ID_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = scan[ID_W-1:0];
            end
        end
        ptr_next = {1'b0, win_idx} + (ID_W+1)'(1);
        if (ptr_next == C_NUM_REQ) begin
            ptr_next = '0;
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        gnt_d       = gnt_q;
        job_done_d  = '0;
        eng_start_d = eng_start_q;
        eng_sel_d   = eng_sel_q;
        busy_d      = busy_q;
        proto_err_d = proto_err_q;

        case (state_q)
            S_IDLE: begin
                // A done seen while no job is outstanding is stale.
                if (eng_done) begin
                    proto_err_d = 1'b1;
                end
                if (win_found) begin
                    state_d          = S_RUN;
                    gnt_d            = '0;
                    gnt_d[win_idx]   = 1'b1;
                    eng_sel_d        = win_idx;
                    eng_start_d      = 1'b1;
                    busy_d           = 1'b1;
                    rr_ptr_d         = ptr_next[ID_W-1:0];
                end
            end
            S_RUN: begin
                if (eng_done) begin
                    state_d     = S_DRAIN;
                    eng_start_d = 1'b0;
                end
            end
            S_DRAIN: begin
                if (!eng_done) begin
                    state_d    = S_RELEASE;
                    gnt_d      = '0;
                    job_done_d = gnt_q;
                end
            end
            S_RELEASE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            gnt_q       <= '0;
            job_done_q  <= '0;
            eng_start_q <= 1'b0;
            eng_sel_q   <= '0;
            busy_q      <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            gnt_q       <= gnt_d;
            job_done_q  <= job_done_d;
            eng_start_q <= eng_start_d;
            eng_sel_q   <= eng_sel_d;
            busy_q      <= busy_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign gnt       = gnt_q;
    assign job_done  = job_done_q;
    assign eng_start = eng_start_q;
    assign eng_sel   = eng_sel_q;
    assign busy      = busy_q;
    assign proto_err = proto_err_q;

`ifdef MATMUL_ARB_PERF_EN
    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] perf_busy_q, perf_busy_d;
    logic [CNT_W-1:0] perf_jobs_q, perf_jobs_d;

    // Both counters stick at all-ones rather than wrapping.
    always_comb begin
        perf_busy_d = perf_busy_q;
        perf_jobs_d = perf_jobs_q;
        if (busy_q && !(&perf_busy_q)) begin
            perf_busy_d = perf_busy_q + C_CNT_ONE;
        end
        if ((state_q == S_RELEASE) && !(&perf_jobs_q)) begin
            perf_jobs_d = perf_jobs_q + C_CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_busy_q <= '0;
            perf_jobs_q <= '0;
        end else begin
            perf_busy_q <= perf_busy_d;
            perf_jobs_q <= perf_jobs_d;
        end
    end

    assign perf_busy_cycles = perf_busy_q;
    assign perf_jobs        = perf_jobs_q;
`else
    assign perf_busy_cycles = '0;
    assign perf_jobs        = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_matmul_job_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_matmul_job_arbiter
// Purpose  : Self-checking bench for matmul_job_arbiter with an engine model
//            and a queue of expected grant winners.
// Revision : 1.0 - initial release
// ============================================================================
module tb_matmul_job_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int CNT_W   = 32;

`ifdef MATMUL_ARB_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;
    logic [NUM_REQ-1:0] job_done;
    logic               eng_start;
    logic               eng_done;
    logic [ID_W-1:0]    eng_sel;
    logic               busy;
    logic               proto_err;
    logic [CNT_W-1:0]   perf_busy_cycles;
    logic [CNT_W-1:0]   perf_jobs;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_q[$];

    bit                 ok;
    int                 sel;
    int                 exp_w;
    logic [NUM_REQ-1:0] g, jd, g_rel, jd_next, oh;
    logic               st_after, busy_next;

    matmul_job_arbiter #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .req              (req),
        .gnt              (gnt),
        .job_done         (job_done),
        .eng_start        (eng_start),
        .eng_done         (eng_done),
        .eng_sel          (eng_sel),
        .busy             (busy),
        .proto_err        (proto_err),
        .perf_busy_cycles (perf_busy_cycles),
        .perf_jobs        (perf_jobs)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Stimulus-only reset: 2 cycles of rst, returns on a falling edge with rst low.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req = '0; eng_done = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Engine model: waits for eng_start, holds for lat cycles, raises then drops
    // eng_done, and reports what the arbiter showed along the way.
    task automatic engine_job(input int lat, output bit t_ok, output int t_sel,
                              output logic [NUM_REQ-1:0] t_g, output logic t_st_after,
                              output logic [NUM_REQ-1:0] t_jd, output logic [NUM_REQ-1:0] t_g_rel,
                              output logic [NUM_REQ-1:0] t_jd_next, output logic t_busy_next);
        t_ok = 1'b0; t_sel = -1; t_g = 'x; t_st_after = 1'bx;
        t_jd = 'x; t_g_rel = 'x; t_jd_next = 'x; t_busy_next = 1'bx;
        for (int i = 0; i < 64; i++) begin
            if (eng_start === 1'b1) begin
                t_ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!t_ok) return;
        t_sel = int'(eng_sel);
        t_g   = gnt;
        repeat (lat) @(negedge clk);
        eng_done = 1'b1;
        @(negedge clk);
        t_st_after = eng_start;
        eng_done   = 1'b0;
        @(negedge clk);
        t_jd    = job_done;
        t_g_rel = gnt;
        @(negedge clk);
        t_jd_next   = job_done;
        t_busy_next = busy;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
        n_tests++; if (job_done !== 4'b0000) begin n_fail++; $display("FAIL reset_job_done: got %b want 0000", job_done); end
        n_tests++; if (eng_start !== 1'b0) begin n_fail++; $display("FAIL reset_eng_start: got %b want 0", eng_start); end
        n_tests++; if (eng_sel !== 2'd0) begin n_fail++; $display("FAIL reset_eng_sel: got %0d want 0", eng_sel); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_tests++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL reset_proto_err: got %b want 0", proto_err); end
        n_tests++; if (perf_busy_cycles !== 32'd0) begin n_fail++; $display("FAIL reset_perf_busy: got %0d want 0", perf_busy_cycles); end
        n_tests++; if (perf_jobs !== 32'd0) begin n_fail++; $display("FAIL reset_perf_jobs: got %0d want 0", perf_jobs); end
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0100;
        exp_q.push_back(2);
        @(negedge clk);
        n_tests++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL single_gnt_latency: got %b want 0100", gnt); end
        n_tests++; if (eng_start !== 1'b1) begin n_fail++; $display("FAIL single_eng_start: got %b want 1", eng_start); end
        n_tests++; if (eng_sel !== 2'd2) begin n_fail++; $display("FAIL single_eng_sel: got %0d want 2", eng_sel); end
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b want 1", busy); end
        engine_job(20, ok, sel, g, st_after, jd, g_rel, jd_next, busy_next);
        req   = '0;
        exp_w = exp_q.pop_front();
        oh = '0; oh[exp_w] = 1'b1;
        n_tests++; if (!ok) begin n_fail++; $display("FAIL single_timeout: eng_start got 0 want 1"); end
        n_tests++; if (sel !== exp_w) begin n_fail++; $display("FAIL single_sel: got %0d want %0d", sel, exp_w); end
        n_tests++; if (st_after !== 1'b0) begin n_fail++; $display("FAIL single_start_drop: got %b want 0", st_after); end
        n_tests++; if (jd !== oh) begin n_fail++; $display("FAIL single_job_done: got %b want %b", jd, oh); end
        n_tests++; if (g_rel !== 4'b0000) begin n_fail++; $display("FAIL single_gnt_release: got %b want 0000", g_rel); end
        n_tests++; if (jd_next !== 4'b0000) begin n_fail++; $display("FAIL single_job_done_width: got %b want 0000", jd_next); end
        n_tests++; if (busy_next !== 1'b0) begin n_fail++; $display("FAIL single_busy_after: got %b want 0", busy_next); end
        n_tests++; if (perf_busy_cycles !== (PERF ? 32'd23 : 32'd0)) begin n_fail++; $display("FAIL single_perf_busy: got %0d want %0d", perf_busy_cycles, PERF ? 23 : 0); end
        n_tests++; if (perf_jobs !== (PERF ? 32'd1 : 32'd0)) begin n_fail++; $display("FAIL single_perf_jobs: got %0d want %0d", perf_jobs, PERF ? 1 : 0); end
    endtask

    // Job j uses engine latency j, so job 0 also covers done arriving on RUN entry.
    task automatic test_round_robin();
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < 8; k++) exp_q.push_back(k % NUM_REQ);
        for (int j = 0; j < 8; j++) begin
            engine_job(j, ok, sel, g, st_after, jd, g_rel, jd_next, busy_next);
            if (j == 7) req = '0;
            exp_w = exp_q.pop_front();
            oh = '0; oh[exp_w] = 1'b1;
            n_tests++; if (!ok) begin n_fail++; $display("FAIL rr_timeout: job %0d eng_start got 0 want 1", j); end
            n_tests++; if (g !== oh) begin n_fail++; $display("FAIL rr_gnt: job %0d got %b want %b", j, g, oh); end
            n_tests++; if (jd !== oh) begin n_fail++; $display("FAIL rr_job_done: job %0d got %b want %b", j, jd, oh); end
        end
        n_tests++; if (perf_jobs !== (PERF ? 32'd8 : 32'd0)) begin n_fail++; $display("FAIL rr_perf_jobs: got %0d want %0d", perf_jobs, PERF ? 8 : 0); end
        n_tests++; if (perf_busy_cycles !== (PERF ? 32'd52 : 32'd0)) begin n_fail++; $display("FAIL rr_perf_busy: got %0d want %0d", perf_busy_cycles, PERF ? 52 : 0); end
    endtask

    task automatic test_withdrawal();
        req = 4'b0010;
        exp_q.push_back(1);
        @(negedge clk);
        req = '0;
        engine_job(5, ok, sel, g, st_after, jd, g_rel, jd_next, busy_next);
        exp_w = exp_q.pop_front();
        oh = '0; oh[exp_w] = 1'b1;
        n_tests++; if (sel !== exp_w) begin n_fail++; $display("FAIL withdraw_sel: got %0d want %0d", sel, exp_w); end
        n_tests++; if (jd !== oh) begin n_fail++; $display("FAIL withdraw_job_done: got %b want %b", jd, oh); end
        n_tests++; if (jd_next !== 4'b0000) begin n_fail++; $display("FAIL withdraw_single_pulse: got %b want 0000", jd_next); end
        repeat (3) @(negedge clk);
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL withdraw_no_regrant: busy got %b want 0", busy); end
    endtask

    task automatic test_hog();
        req = 4'b0001;
        exp_q.push_back(0); exp_q.push_back(3); exp_q.push_back(0);
        @(negedge clk);
        req = 4'b1001;
        for (int j = 0; j < 3; j++) begin
            engine_job(3, ok, sel, g, st_after, jd, g_rel, jd_next, busy_next);
            if (j == 2) req = '0;
            exp_w = exp_q.pop_front();
            n_tests++; if (sel !== exp_w) begin n_fail++; $display("FAIL hog_sel: job %0d got %0d want %0d", j, sel, exp_w); end
        end
    endtask

    task automatic test_proto_err();
        n_tests++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL proto_clean: got %b want 0", proto_err); end
        eng_done = 1'b1;
        @(negedge clk);
        eng_done = 1'b0;
        n_tests++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL proto_set: got %b want 1", proto_err); end
        repeat (5) @(negedge clk);
        n_tests++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL proto_sticky: got %b want 1", proto_err); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL proto_idle: busy got %b want 0", busy); end
        do_reset();
        n_tests++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL proto_clear: got %b want 0", proto_err); end
    endtask

    task automatic test_mid_reset();
        req = 4'b0100;
        @(negedge clk);
        repeat (3) @(negedge clk);
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midrst_running: busy got %b want 1", busy); end
        rst = 1'b1;
        @(negedge clk);
        n_tests++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL midrst_gnt: got %b want 0000", gnt); end
        n_tests++; if (eng_start !== 1'b0) begin n_fail++; $display("FAIL midrst_eng_start: got %b want 0", eng_start); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", busy); end
        n_tests++; if (job_done !== 4'b0000) begin n_fail++; $display("FAIL midrst_job_done: got %b want 0000", job_done); end
        n_tests++; if (perf_busy_cycles !== 32'd0) begin n_fail++; $display("FAIL midrst_perf_busy: got %0d want 0", perf_busy_cycles); end
        n_tests++; if (perf_jobs !== 32'd0) begin n_fail++; $display("FAIL midrst_perf_jobs: got %0d want 0", perf_jobs); end
        rst = 1'b0;
        req = 4'b1111;
        exp_q.push_back(0);
        engine_job(2, ok, sel, g, st_after, jd, g_rel, jd_next, busy_next);
        req = '0;
        exp_w = exp_q.pop_front();
        n_tests++; if (sel !== exp_w) begin n_fail++; $display("FAIL midrst_rr_ptr: got %0d want %0d", sel, exp_w); end
        n_tests++; if (jd_next !== 4'b0000) begin n_fail++; $display("FAIL midrst_job_done_pulse: got %b want 0000", jd_next); end
    endtask

    initial begin
        rst = 1'b1; req = '0; eng_done = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_withdrawal();
        test_hog();
        test_proto_err();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
